// File: rtl/csr_regfile_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, mstatus/mip bit positions,
// interrupt cause codes and the misa encoding.
package csr_regfile_pkg;

    localparam int          CSR_XLEN         = 64;
    localparam int          CSR_ADDR_W       = 12;
    localparam int          CSR_ECAUSE_W     = 6;
    localparam int          CSR_RETIRE_W     = 2;
    localparam logic [63:0] CSR_RESET_VECTOR = 64'h0000_0000_8000_0000;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_CYCLE     = 12'hC00,
        CSR_INSTRET   = 12'hC02,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12,
        CSR_MIMPID    = 12'hF13,
        CSR_MHARTID   = 12'hF14
    } csr_addr_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    localparam int MIP_MSIP = 3;
    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    localparam logic [5:0] IRQ_CAUSE_MSI = 6'd3;
    localparam logic [5:0] IRQ_CAUSE_MTI = 6'd7;
    localparam logic [5:0] IRQ_CAUSE_MEI = 6'd11;

    localparam logic [1:0] MISA_MXL_64 = 2'b10;
    localparam int         MISA_EXT_I  = 8;
    localparam int         MISA_EXT_M  = 12;

endpackage

// File: rtl/csr_regfile_if.sv
// CSR access port between the execute unit (master) and the CSR file (slave):
// a combinational read port and a next-edge write port.
interface csr_regfile_if
    import csr_regfile_pkg::*;
#(
    parameter int XLEN         = CSR_XLEN,
    parameter int CSR_ADDR_LEN = CSR_ADDR_W
);
    logic [CSR_ADDR_LEN-1:0] csr_raddr_i;
    logic [XLEN-1:0]         csr_rdata_o;
    logic                    csr_readable_o;
    logic                    csr_writable_o;
    logic [CSR_ADDR_LEN-1:0] csr_waddr_i;
    logic [XLEN-1:0]         csr_wrdata_i;
    logic                    do_csr_write_i;

    modport master (
        output csr_raddr_i, csr_waddr_i, csr_wrdata_i, do_csr_write_i,
        input  csr_rdata_o, csr_readable_o, csr_writable_o
    );

    modport slave (
        input  csr_raddr_i, csr_waddr_i, csr_wrdata_i, do_csr_write_i,
        output csr_rdata_o, csr_readable_o, csr_writable_o
    );
endinterface

// File: rtl/csr_regfile_counter.sv
// Wrapping event counter; a software load in the same cycle replaces the increment.
module csr_regfile_counter #(
    parameter int WIDTH = 64,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use <= so every flop samples pre-edge values, whatever the block order.
        if (!rst) begin
            count <= '0;
        end else if (wr_en) begin
            count <= wr_data;
        end else begin
            count <= count + WIDTH'(inc);
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: read mux, masked writes, trap/mret side effects, cycle/instret
// counters and interrupt-pending detection for the ROB.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int              XLEN         = CSR_XLEN,
    parameter int              CSR_ADDR_LEN = CSR_ADDR_W,
    parameter int              ECAUSE_WIDTH = CSR_ECAUSE_W,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(CSR_RESET_VECTOR),
    parameter int              RETIRE_WIDTH = CSR_RETIRE_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    csr_regfile_if.slave                         csr,
    input  logic                                 trap_valid_i,
    input  logic                                 trap_is_irq_i,
    input  logic [ECAUSE_WIDTH-1:0]              trap_cause_i,
    input  logic [XLEN-1:0]                      trap_pc_i,
    input  logic [XLEN-1:0]                      trap_tval_i,
    input  logic                                 mret_valid_i,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0]    retire_cnt_i,
    input  logic                                 ext_irq_i,
    input  logic                                 sw_irq_i,
    input  logic                                 timer_irq_i,
    output logic [XLEN-1:0]                      mtvec_o,
    output logic [XLEN-1:0]                      mepc_o,
    output logic                                 irq_pending_o,
    output logic [ECAUSE_WIDTH-1:0]              irq_cause_o
);

    localparam int RETIRE_CNT_W = $clog2(RETIRE_WIDTH + 1);

    localparam logic [XLEN-1:0] MIE_WR_MASK =
        (XLEN'(1) << MIP_MSIP) | (XLEN'(1) << MIP_MTIP) | (XLEN'(1) << MIP_MEIP);

    logic            mstatus_mie_q;
    logic            mstatus_mpie_q;
    logic [XLEN-1:0] mie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;

    logic [XLEN-1:0] mstatus_rd;
    logic [XLEN-1:0] mip_rd;
    logic [XLEN-1:0] misa_rd;
    logic [XLEN-1:0] mcause_trap;
    logic [XLEN-1:0] irq_active;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc;
    logic wr_mcause, wr_mtval, wr_mcycle, wr_minstret;

    function automatic logic wr_hit(input logic [CSR_ADDR_LEN-1:0] waddr, input csr_addr_e target);
        return waddr == CSR_ADDR_LEN'(target);
    endfunction

    assign wr_mstatus  = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MSTATUS);
    assign wr_mie      = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MIE);
    assign wr_mtvec    = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MTVEC);
    assign wr_mscratch = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MSCRATCH);
    assign wr_mepc     = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MEPC);
    assign wr_mcause   = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MCAUSE);
    assign wr_mtval    = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MTVAL);
    assign wr_mcycle   = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MCYCLE);
    assign wr_minstret = csr.do_csr_write_i && wr_hit(csr.csr_waddr_i, CSR_MINSTRET);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        mstatus_rd                       = '0;
        mstatus_rd[MSTATUS_MIE]          = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE]         = mstatus_mpie_q;
        mstatus_rd[MSTATUS_MPP_LO +: 2]  = 2'b11;

        mip_rd                           = '0;
        mip_rd[MIP_MSIP]                 = sw_irq_i;
        mip_rd[MIP_MTIP]                 = timer_irq_i;
        mip_rd[MIP_MEIP]                 = ext_irq_i;

        misa_rd                          = '0;
        misa_rd[XLEN-1 -: 2]             = MISA_MXL_64;
        misa_rd[MISA_EXT_I]              = 1'b1;
        misa_rd[MISA_EXT_M]              = 1'b1;

        mcause_trap                      = '0;
        mcause_trap[XLEN-1]              = trap_is_irq_i;
        mcause_trap[ECAUSE_WIDTH-1:0]    = trap_cause_i;
    end

    // A trap outranks mret, and both outrank a software write to mstatus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else if (trap_valid_i) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_valid_i) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie_q  <= csr.csr_wrdata_i[MSTATUS_MIE];
            mstatus_mpie_q <= csr.csr_wrdata_i[MSTATUS_MPIE];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (trap_valid_i) begin
            mepc_q   <= trap_pc_i & ~XLEN'(1);
            mcause_q <= mcause_trap;
            mtval_q  <= trap_tval_i;
        end else begin
            if (wr_mepc)   mepc_q   <= csr.csr_wrdata_i & ~XLEN'(1);
            if (wr_mcause) mcause_q <= csr.csr_wrdata_i;
            if (wr_mtval)  mtval_q  <= csr.csr_wrdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_q      <= '0;
            mtvec_q    <= RESET_VECTOR;
            mscratch_q <= '0;
        end else begin
            if (wr_mie)      mie_q      <= csr.csr_wrdata_i & MIE_WR_MASK;
            if (wr_mtvec)    mtvec_q    <= csr.csr_wrdata_i & ~XLEN'(3);
            if (wr_mscratch) mscratch_q <= csr.csr_wrdata_i;
        end
    end

    csr_regfile_counter #(.WIDTH(XLEN), .INC_W(RETIRE_CNT_W)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc     (RETIRE_CNT_W'(1)),
        .wr_en   (wr_mcycle),
        .wr_data (csr.csr_wrdata_i),
        .count   (mcycle)
    );

    csr_regfile_counter #(.WIDTH(XLEN), .INC_W(RETIRE_CNT_W)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc     (retire_cnt_i),
        .wr_en   (wr_minstret),
        .wr_data (csr.csr_wrdata_i),
        .count   (minstret)
    );

    // Read mux: same-cycle reads see committed state, so a write is visible only after its edge.
    always_comb begin
        csr.csr_rdata_o    = '0;
        csr.csr_readable_o = 1'b1;
        case (csr.csr_raddr_i)
            CSR_ADDR_LEN'(CSR_MVENDORID),
            CSR_ADDR_LEN'(CSR_MARCHID),
            CSR_ADDR_LEN'(CSR_MIMPID),
            CSR_ADDR_LEN'(CSR_MHARTID):   csr.csr_rdata_o = '0;
            CSR_ADDR_LEN'(CSR_MSTATUS):   csr.csr_rdata_o = mstatus_rd;
            CSR_ADDR_LEN'(CSR_MISA):      csr.csr_rdata_o = misa_rd;
            CSR_ADDR_LEN'(CSR_MIE):       csr.csr_rdata_o = mie_q;
            CSR_ADDR_LEN'(CSR_MTVEC):     csr.csr_rdata_o = mtvec_q;
            CSR_ADDR_LEN'(CSR_MSCRATCH):  csr.csr_rdata_o = mscratch_q;
            CSR_ADDR_LEN'(CSR_MEPC):      csr.csr_rdata_o = mepc_q;
            CSR_ADDR_LEN'(CSR_MCAUSE):    csr.csr_rdata_o = mcause_q;
            CSR_ADDR_LEN'(CSR_MTVAL):     csr.csr_rdata_o = mtval_q;
            CSR_ADDR_LEN'(CSR_MIP):       csr.csr_rdata_o = mip_rd;
            CSR_ADDR_LEN'(CSR_MCYCLE),
            CSR_ADDR_LEN'(CSR_CYCLE):     csr.csr_rdata_o = mcycle;
            CSR_ADDR_LEN'(CSR_MINSTRET),
            CSR_ADDR_LEN'(CSR_INSTRET):   csr.csr_rdata_o = minstret;
            default:                      csr.csr_readable_o = 1'b0;
        endcase
    end

    assign csr.csr_writable_o = csr.csr_readable_o &&
                                (csr.csr_raddr_i[CSR_ADDR_LEN-1 -: 2] != 2'b11);

    // Cause priority among enabled pending sources: external, then software, then timer.
    assign irq_active    = mie_q & mip_rd;
    assign irq_pending_o = mstatus_mie_q && (|irq_active);

    always_comb begin
        irq_cause_o = '0;
        if (irq_active[MIP_MEIP]) begin
            irq_cause_o = ECAUSE_WIDTH'(IRQ_CAUSE_MEI);
        end else if (irq_active[MIP_MSIP]) begin
            irq_cause_o = ECAUSE_WIDTH'(IRQ_CAUSE_MSI);
        end else if (irq_active[MIP_MTIP]) begin
            irq_cause_o = ECAUSE_WIDTH'(IRQ_CAUSE_MTI);
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: a table of single-write vectors plus hand-written
// sequences for counters, trap/mret, interrupts and reset in mid-run.
module tb_csr_regfile;

    logic        clk;
    logic        rst;
    logic        trap_valid, trap_is_irq, mret_valid;
    logic [5:0]  trap_cause;
    logic [63:0] trap_pc, trap_tval;
    logic [1:0]  retire_cnt;
    logic        ext_irq, sw_irq, timer_irq;
    logic [63:0] mtvec, mepc;
    logic        irq_pending;
    logic [5:0]  irq_cause;

    int n_vec;
    int n_err;

    csr_regfile_if #(.XLEN(64), .CSR_ADDR_LEN(12)) bus ();

    csr_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .csr           (bus),
        .trap_valid_i  (trap_valid),
        .trap_is_irq_i (trap_is_irq),
        .trap_cause_i  (trap_cause),
        .trap_pc_i     (trap_pc),
        .trap_tval_i   (trap_tval),
        .mret_valid_i  (mret_valid),
        .retire_cnt_i  (retire_cnt),
        .ext_irq_i     (ext_irq),
        .sw_irq_i      (sw_irq),
        .timer_irq_i   (timer_irq),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc),
        .irq_pending_o (irq_pending),
        .irq_cause_o   (irq_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_before;
        logic        exp_rd;
        logic        exp_wr;
        logic [63:0] exp_after;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string name, input logic [11:0] addr, input logic [63:0] exp);
        bus.csr_raddr_i = addr;
        #1;
        check(name, bus.csr_rdata_o, exp);
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
        bus.csr_waddr_i    = addr;
        bus.csr_wrdata_i   = data;
        bus.do_csr_write_i = 1'b1;
        tick();
        bus.do_csr_write_i = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        trap_valid = 0; trap_is_irq = 0; mret_valid = 0;
        trap_cause = '0; trap_pc = '0; trap_tval = '0;
        retire_cnt = '0; ext_irq = 0; sw_irq = 0; timer_irq = 0;
        bus.csr_raddr_i = '0; bus.csr_waddr_i = '0;
        bus.csr_wrdata_i = '0; bus.do_csr_write_i = 1'b0;

        //            addr     wdata                    before                   rd wr after
        vecs[0]  = '{12'h340, 64'h0000_0000_DEAD_BEEF, 64'h0,                   1, 1, 64'h0000_0000_DEAD_BEEF};
        vecs[1]  = '{12'h305, 64'h7,                   64'h8000_0000,           1, 1, 64'h4};
        vecs[2]  = '{12'h301, 64'h0,                   64'h8000_0000_0000_1100, 1, 1, 64'h8000_0000_0000_1100};
        vecs[3]  = '{12'h7C0, 64'hFFFF,                64'h0,                   0, 0, 64'h0};
        vecs[4]  = '{12'hF11, 64'h5,                   64'h0,                   1, 0, 64'h0};
        vecs[5]  = '{12'h341, 64'h1235,                64'h0,                   1, 1, 64'h1234};
        vecs[6]  = '{12'h304, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1, 1, 64'h888};
        vecs[7]  = '{12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1800,                1, 1, 64'h1888};
        vecs[8]  = '{12'h300, 64'h0,                   64'h1888,                1, 1, 64'h1800};
        vecs[9]  = '{12'h342, 64'h8000_0000_0000_0007, 64'h0,                   1, 1, 64'h8000_0000_0000_0007};
        vecs[10] = '{12'h343, 64'hABC,                 64'h0,                   1, 1, 64'hABC};
        vecs[11] = '{12'h344, 64'hFFF,                 64'h0,                   1, 1, 64'h0};
        vecs[12] = '{12'hF14, 64'h1,                   64'h0,                   1, 0, 64'h0};
        vecs[13] = '{12'hC00, 64'h77,                  64'h0,                   1, 0, 64'h0};

        // Reset state while rst is held low
        #12;
        check("rst_mtvec_o", mtvec, 64'h8000_0000);
        read_chk("rst_mstatus", 12'h300, 64'h1800);
        check("rst_irq_pending", {63'h0, irq_pending}, 64'h0);
        read_chk("rst_mcycle", 12'hB00, 64'h0);

        // Vector table; cycle counter keeps running, so hold rst through the C00 vector only
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].addr == 12'hC00) rst = 1'b0;
            bus.csr_raddr_i    = vecs[i].addr;
            bus.csr_waddr_i    = vecs[i].addr;
            bus.csr_wrdata_i   = vecs[i].wdata;
            bus.do_csr_write_i = 1'b1;
            #1;
            check($sformatf("vec%0d_same_cycle", i), bus.csr_rdata_o, vecs[i].exp_before);
            check($sformatf("vec%0d_readable", i), {63'h0, bus.csr_readable_o}, {63'h0, vecs[i].exp_rd});
            check($sformatf("vec%0d_writable", i), {63'h0, bus.csr_writable_o}, {63'h0, vecs[i].exp_wr});
            tick();
            bus.do_csr_write_i = 1'b0;
            #1;
            check($sformatf("vec%0d_after", i), bus.csr_rdata_o, vecs[i].exp_after);
        end

        // Restart from reset for the multi-cycle sequences
        @(negedge clk);
        rst = 1'b1;
        tick();
        read_chk("mcycle_one_after_release", 12'hB00, 64'h1);
        read_chk("minstret_start", 12'hB02, 64'h0);
        retire_cnt = 2'd2;
        tick(); tick(); tick();
        retire_cnt = 2'd0;
        read_chk("minstret_plus6", 12'hB02, 64'h6);
        read_chk("instret_shadow", 12'hC02, 64'h6);

        bus.csr_raddr_i = 12'hB00;
        csr_write(12'hB00, 64'h5);
        read_chk("mcycle_wr5", 12'hB00, 64'h5);
        tick();
        read_chk("mcycle_wr5_plus1", 12'hB00, 64'h6);

        retire_cnt = 2'd2;
        csr_write(12'hB02, 64'hA);
        retire_cnt = 2'd0;
        read_chk("minstret_wr_wins", 12'hB02, 64'hA);

        csr_write(12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        retire_cnt = 2'd1;
        read_chk("minstret_all_ones", 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        retire_cnt = 2'd0;
        read_chk("minstret_wrap", 12'hB02, 64'h0);

        // Trap with a same-cycle mepc write, then mret
        csr_write(12'h300, 64'h8);
        read_chk("mstatus_mie_set", 12'h300, 64'h1808);
        trap_valid = 1; trap_is_irq = 0; trap_cause = 6'd2;
        trap_pc = 64'h1001; trap_tval = 64'h55;
        bus.csr_waddr_i = 12'h341; bus.csr_wrdata_i = 64'h9998; bus.do_csr_write_i = 1'b1;
        tick();
        trap_valid = 0; bus.do_csr_write_i = 1'b0;
        #1;
        check("trap_mepc_o", mepc, 64'h1000);
        read_chk("trap_mcause", 12'h342, 64'h2);
        read_chk("trap_mtval", 12'h343, 64'h55);
        read_chk("trap_mstatus", 12'h300, 64'h1880);
        mret_valid = 1;
        tick();
        mret_valid = 0;
        read_chk("mret_mstatus", 12'h300, 64'h1888);

        trap_valid = 1; mret_valid = 1; trap_is_irq = 1; trap_cause = 6'd11;
        trap_pc = 64'h2000; trap_tval = 64'h0;
        tick();
        trap_valid = 0; mret_valid = 0;
        read_chk("trap_mret_mstatus", 12'h300, 64'h1880);
        read_chk("trap_mret_mcause", 12'h342, 64'h8000_0000_0000_000B);
        check("trap_mret_mepc_o", mepc, 64'h2000);

        mret_valid = 1;
        csr_write(12'h300, 64'h0);
        mret_valid = 0;
        read_chk("mret_beats_write", 12'h300, 64'h1888);

        // Interrupt detection and priority
        csr_write(12'h304, 64'h888);
        timer_irq = 1; ext_irq = 1;
        read_chk("mip_timer_ext", 12'h344, 64'h880);
        check("irq_pend_te", {63'h0, irq_pending}, 64'h1);
        check("irq_cause_te", {58'h0, irq_cause}, 64'd11);
        ext_irq = 0;
        #1;
        check("irq_cause_t", {58'h0, irq_cause}, 64'd7);
        sw_irq = 1;
        #1;
        check("irq_cause_st", {58'h0, irq_cause}, 64'd3);
        csr_write(12'h304, 64'h080);
        sw_irq = 0;
        ext_irq = 1;
        #1;
        check("irq_cause_masked", {58'h0, irq_cause}, 64'd7);
        timer_irq = 0;
        #1;
        check("irq_pend_masked", {63'h0, irq_pending}, 64'h0);
        timer_irq = 1;
        csr_write(12'h300, 64'h0);
        check("irq_pend_mie_clr", {63'h0, irq_pending}, 64'h0);

        // Reset in mid-run with a pending write
        csr_write(12'h340, 64'hCAFE);
        bus.csr_waddr_i = 12'h340; bus.csr_wrdata_i = 64'h1234; bus.do_csr_write_i = 1'b1;
        #1;
        rst = 1'b0;
        read_chk("midrst_mscratch_async", 12'h340, 64'h0);
        tick();
        bus.do_csr_write_i = 1'b0;
        check("midrst_mtvec_o", mtvec, 64'h8000_0000);
        check("midrst_mepc_o", mepc, 64'h0);
        read_chk("midrst_mstatus", 12'h300, 64'h1800);
        read_chk("midrst_mie", 12'h304, 64'h0);
        read_chk("midrst_minstret", 12'h202 | 12'h900, 64'h0);
        check("midrst_irq_pending", {63'h0, irq_pending}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        read_chk("postrst_mscratch", 12'h340, 64'h0);
        read_chk("postrst_mcycle", 12'hB00, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
